// File: rtl/pipeline_batch_driver.sv
// pipeline_batch_driver: feeds batches of bots into a scoring pipeline and
// returns its per-batch results, each tagged with the batch it belongs to.
// Batch tags wait in an in-flight FIFO until the matching result comes back.
module pipeline_batch_driver #(
  parameter int COUNT_W       = 35,
  parameter int TAG_W         = 8,
  parameter int INFLIGHT_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  // upstream bot stream
  input  logic                 botValidIn,
  input  logic [127:0]         botIn,
  input  logic [5:0]           botPermutesIn,
  input  logic                 botLastIn,
  input  logic [TAG_W-1:0]     batchTagIn,
  output logic                 botReady,
  // pipeline write port
  output logic                 writeData,
  output logic [127:0]         bot,
  output logic [5:0]           validBotPermutes,
  output logic                 batchDone,
  input  logic                 slowDownInput,
  // pipeline result port
  input  logic                 resultsAvailable,
  input  logic [COUNT_W+34:0]  pcoeffSum,
  input  logic [COUNT_W-1:0]   pcoeffCount,
  output logic                 grabResults,
  // downstream tagged results
  output logic                 resultValid,
  input  logic                 resultReady,
  output logic [TAG_W-1:0]     resultTag,
  output logic [COUNT_W+34:0]  resultSum,
  output logic [COUNT_W-1:0]   resultCount,
  // statistics
  output logic [31:0]          batchesSent,
  output logic [31:0]          batchesReturned,
  output logic [31:0]          droppedBots,
  output logic                 protocolError
);

  localparam int SUM_W = COUNT_W + 35;
  localparam int DEPTH = 1 << INFLIGHT_LOG2;
  localparam logic [INFLIGHT_LOG2:0]   CNT_ONE  = (INFLIGHT_LOG2+1)'(1);
  localparam logic [INFLIGHT_LOG2:0]   CNT_FULL = (INFLIGHT_LOG2+1)'(DEPTH);
  localparam logic [INFLIGHT_LOG2-1:0] PTR_ONE  = INFLIGHT_LOG2'(1);

  typedef enum logic {S_IDLE, S_IN_BATCH} state_t;

  state_t                   state_q;
  logic [TAG_W-1:0]         open_tag_q;
  logic                     ready_q;
  logic                     write_q;
  logic [127:0]             bot_q;
  logic [5:0]               perm_q;
  logic                     done_q;
  logic                     grab_q;
  logic                     rvalid_q;
  logic [TAG_W-1:0]         rtag_q;
  logic [SUM_W-1:0]         rsum_q;
  logic [COUNT_W-1:0]       rcnt_q;
  logic [31:0]              sent_q;
  logic [31:0]              ret_q;
  logic [31:0]              drop_q;
  logic                     perr_q;
  logic [INFLIGHT_LOG2-1:0] wr_ptr_q;
  logic [INFLIGHT_LOG2-1:0] rd_ptr_q;
  logic [INFLIGHT_LOG2:0]   count_q;
  logic [INFLIGHT_LOG2:0]   count_d;
  logic [TAG_W-1:0]         tag_mem [DEPTH];

  logic             accept;
  logic             push_tag;
  logic [TAG_W-1:0] push_value;
  logic             grab;
  logic             pop_tag;
  logic             keep_bot;

  // Handshake and tag-FIFO control; botReady is a register so botValidIn never
  // loops back into it combinationally.
  always_comb begin
    accept     = rst && botValidIn && ready_q;
    push_tag   = accept && botLastIn;
    push_value = (state_q == S_IDLE) ? batchTagIn : open_tag_q;
    keep_bot   = (botPermutesIn != 6'd0) || botLastIn;
    grab       = rst && resultsAvailable && (!rvalid_q || resultReady) && !grab_q;
    pop_tag    = grab && (count_q != '0);
    count_d    = count_q;
    if (push_tag && !pop_tag) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_tag && pop_tag) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Batch framing FSM: remembers the tag of the batch currently being sent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      open_tag_q <= '0;
    end else if (accept) begin
      if (botLastIn) begin
        state_q <= S_IDLE;
      end else begin
        state_q <= S_IN_BATCH;
        if (state_q == S_IDLE) begin
          open_tag_q <= batchTagIn;
        end
      end
    end
  end

  // Ready register: closes on backpressure or when the tag FIFO will be full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= !slowDownInput && (count_d != CNT_FULL);
    end
  end

  // Pipeline write port: one cycle after acceptance; empty non-last bots are
  // dropped, but a last bot is always written so the batch gets closed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_q <= 1'b0;
      bot_q   <= '0;
      perm_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      write_q <= accept && keep_bot;
      done_q  <= accept && botLastIn;
      if (accept && keep_bot) begin
        bot_q  <= botIn;
        perm_q <= botPermutesIn;
      end
      if (accept && !keep_bot) begin
        drop_q <= drop_q + 32'd1;
      end
    end
  end

  // Tag FIFO storage, no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_tag) begin
      tag_mem[wr_ptr_q] <= push_value;
    end
  end

  // Tag FIFO pointers, occupancy and sent-batch count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push_tag) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
        sent_q   <= sent_q + 32'd1;
      end
      if (pop_tag) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Result output register: a grab loads pipeline data plus the oldest tag;
  // otherwise data holds until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grab_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rtag_q   <= '0;
      rsum_q   <= '0;
      rcnt_q   <= '0;
      ret_q    <= '0;
      perr_q   <= 1'b0;
    end else begin
      grab_q <= grab;
      if (grab) begin
        rvalid_q <= 1'b1;
        rsum_q   <= pcoeffSum;
        rcnt_q   <= pcoeffCount;
        ret_q    <= ret_q + 32'd1;
        if (pop_tag) begin
          rtag_q <= tag_mem[rd_ptr_q];
        end else begin
          rtag_q <= '0;
          perr_q <= 1'b1;
        end
      end else if (rvalid_q && resultReady) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign botReady         = ready_q;
  assign writeData        = write_q;
  assign bot              = bot_q;
  assign validBotPermutes = perm_q;
  assign batchDone        = done_q;
  assign grabResults      = grab;
  assign resultValid      = rvalid_q;
  assign resultTag        = rtag_q;
  assign resultSum        = rsum_q;
  assign resultCount      = rcnt_q;
  assign batchesSent      = sent_q;
  assign batchesReturned  = ret_q;
  assign droppedBots      = drop_q;
  assign protocolError    = perr_q;

endmodule

// File: tb/tb_pipeline_batch_driver.sv
// Testbench for pipeline_batch_driver: directed scenarios followed by random
// traffic, all checked against a queue-based batch/result model.
module tb_pipeline_batch_driver;

  localparam int CW    = 35;
  localparam int TW    = 8;
  localparam int SW    = CW + 35;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           botValidIn;
  logic [127:0]   botIn;
  logic [5:0]     botPermutesIn;
  logic           botLastIn;
  logic [TW-1:0]  batchTagIn;
  logic           botReady;
  logic           writeData;
  logic [127:0]   bot;
  logic [5:0]     validBotPermutes;
  logic           batchDone;
  logic           slowDownInput;
  logic           resultsAvailable;
  logic [SW-1:0]  pcoeffSum;
  logic [CW-1:0]  pcoeffCount;
  logic           grabResults;
  logic           resultValid;
  logic           resultReady;
  logic [TW-1:0]  resultTag;
  logic [SW-1:0]  resultSum;
  logic [CW-1:0]  resultCount;
  logic [31:0]    batchesSent;
  logic [31:0]    batchesReturned;
  logic [31:0]    droppedBots;
  logic           protocolError;

  pipeline_batch_driver #(.COUNT_W(CW), .TAG_W(TW), .INFLIGHT_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .botValidIn(botValidIn), .botIn(botIn), .botPermutesIn(botPermutesIn),
    .botLastIn(botLastIn), .batchTagIn(batchTagIn), .botReady(botReady),
    .writeData(writeData), .bot(bot), .validBotPermutes(validBotPermutes),
    .batchDone(batchDone), .slowDownInput(slowDownInput),
    .resultsAvailable(resultsAvailable), .pcoeffSum(pcoeffSum),
    .pcoeffCount(pcoeffCount), .grabResults(grabResults),
    .resultValid(resultValid), .resultReady(resultReady),
    .resultTag(resultTag), .resultSum(resultSum), .resultCount(resultCount),
    .batchesSent(batchesSent), .batchesReturned(batchesReturned),
    .droppedBots(droppedBots), .protocolError(protocolError)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            m_ready, m_wd, m_done, m_rv, m_perr, m_gprev, m_inbatch, m_fresh;
  logic [127:0]  m_bot;
  logic [5:0]    m_perm;
  logic [TW-1:0] m_rtag, m_open;
  logic [SW-1:0] m_rsum;
  logic [CW-1:0] m_rcnt;
  int unsigned   m_sent, m_ret, m_drop;
  logic [TW-1:0] tagq[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: check the combinational pop, advance the model, check outputs.
  task automatic cyc();
    bit g, acc, wr;
    logic [TW-1:0] t;
    pcoeffSum   = SW'({$urandom(), $urandom(), $urandom()});
    pcoeffCount = CW'({$urandom(), $urandom()});
    #1;
    g = rst && resultsAvailable && (!m_rv || resultReady) && !m_gprev;
    check("grabResults", grabResults, g);
    if (!rst) begin
      m_ready = 0; m_wd = 0; m_done = 0; m_rv = 0; m_perr = 0; m_gprev = 0;
      m_inbatch = 0; m_bot = '0; m_perm = '0; m_rtag = '0; m_open = '0;
      m_rsum = '0; m_rcnt = '0; m_sent = 0; m_ret = 0; m_drop = 0;
      tagq.delete();
      m_fresh = 1;
    end else begin
      m_fresh = 0;
      acc = botValidIn && m_ready;
      wr  = acc && ((botPermutesIn != 6'd0) || botLastIn);
      m_wd = wr;
      m_done = acc && botLastIn;
      if (wr) begin
        m_bot = botIn;
        m_perm = botPermutesIn;
      end
      if (acc && !wr) m_drop++;
      // results leave before this cycle's tag can arrive
      if (g) begin
        m_ret++;
        m_rv = 1;
        m_rsum = pcoeffSum;
        m_rcnt = pcoeffCount;
        if (tagq.size() > 0) begin
          m_rtag = tagq.pop_front();
        end else begin
          m_rtag = '0;
          m_perr = 1;
        end
      end else if (m_rv && resultReady) begin
        m_rv = 0;
      end
      if (acc) begin
        t = m_inbatch ? m_open : batchTagIn;
        if (botLastIn) begin
          tagq.push_back(t);
          m_sent++;
          m_inbatch = 0;
        end else begin
          if (!m_inbatch) m_open = batchTagIn;
          m_inbatch = 1;
        end
      end
      m_gprev = g;
      m_ready = !slowDownInput && (tagq.size() < DEPTH);
    end
    @(posedge clk);
    #1;
    check("botReady", botReady, m_ready);
    check("writeData", writeData, m_wd);
    check("batchDone", batchDone, m_done);
    check("resultValid", resultValid, m_rv);
    check("protocolError", protocolError, m_perr);
    check("batchesSent", batchesSent, m_sent);
    check("batchesReturned", batchesReturned, m_ret);
    check("droppedBots", droppedBots, m_drop);
    if (m_wd || m_fresh) begin
      check("bot", bot, m_bot);
      check("validBotPermutes", validBotPermutes, m_perm);
    end
    if (m_rv || m_fresh) begin
      check("resultTag", resultTag, m_rtag);
      check("resultSum", resultSum, m_rsum);
      check("resultCount", resultCount, m_rcnt);
    end
    if (m_wd) $display("WR  t=%0t perm=%02h done=%0b", $time, m_perm, m_done);
    if (g)    $display("RES t=%0t tag=%02h perr=%0b", $time, m_rtag, m_perr);
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) cyc();
    rst = 1'b1;
  endtask

  // Present one bot and hold it until the model says it was accepted.
  task automatic send_bot(input logic [127:0] b, input logic [5:0] perm,
                          input bit last, input logic [TW-1:0] tag);
    bit acc;
    bit done = 0;
    botValidIn = 1'b1; botIn = b; botPermutesIn = perm;
    botLastIn = last; batchTagIn = tag;
    for (int i = 0; i < 64 && !done; i++) begin
      acc = m_ready;
      cyc();
      done = acc;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
    botValidIn = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0]  b;
    logic [TW-1:0] first_tag;
    rst = 1'b0; botValidIn = 0; botIn = '0; botPermutesIn = '0; botLastIn = 0;
    batchTagIn = '0; slowDownInput = 0; resultsAvailable = 0; resultReady = 0;
    pcoeffSum = '0; pcoeffCount = '0;
    reset_dut(3);
    cyc();

    // three-bot batch with an empty middle bot
    send_bot(rand128(), 6'h3F, 0, 8'h5A);
    send_bot(rand128(), 6'h00, 0, 8'h11);
    send_bot(rand128(), 6'h01, 1, 8'h22);
    cyc();
    check("req36_dropped", droppedBots, 32'd1);
    check("req36_sent", batchesSent, 32'd1);
    resultsAvailable = 1; resultReady = 1;
    cyc();
    resultsAvailable = 0;
    check("req36_tag", resultTag, 8'h5A);
    cyc();

    // backpressure while a bot is waiting
    send_bot(rand128(), 6'h07, 0, 8'h33);
    slowDownInput = 1;
    cyc();
    check("req37_ready_low", botReady, 1'b0);
    b = rand128();
    botValidIn = 1; botIn = b; botPermutesIn = 6'h2A; botLastIn = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("req37_no_write", writeData, 1'b0);
    end
    slowDownInput = 0;
    send_bot(b, 6'h2A, 1, 8'h44);
    cyc();
    check("req37_sent", batchesSent, 32'd2);

    // fill the tag FIFO with single-bot batches
    reset_dut(1);
    cyc();
    first_tag = 8'h07;
    for (int i = 0; i < DEPTH; i++) send_bot(rand128(), 6'h01, 1, 8'(i * 3 + 7));
    check("req38_full", botReady, 1'b0);
    botValidIn = 1; botLastIn = 1; botPermutesIn = 6'h01;
    cyc();
    cyc();
    botValidIn = 0;
    resultsAvailable = 1; resultReady = 1;
    cyc();
    resultsAvailable = 0;
    check("req38_ready", botReady, 1'b1);
    check("req38_tag", resultTag, first_tag);

    // continuous results with a toggling consumer
    resultsAvailable = 1;
    for (int i = 0; i < 24; i++) begin
      resultReady = i[0];
      cyc();
    end
    resultsAvailable = 0; resultReady = 1;
    cyc();
    cyc();

    // result with nothing outstanding
    reset_dut(1);
    resultsAvailable = 1; resultReady = 1;
    cyc();
    resultsAvailable = 0;
    check("req40_perr", protocolError, 1'b1);
    check("req40_tag", resultTag, 8'h00);
    for (int i = 0; i < 3; i++) cyc();
    check("req40_sticky", protocolError, 1'b1);
    reset_dut(1);
    cyc();
    check("req40_cleared", protocolError, 1'b0);

    // reset in the middle of a batch with two tags queued
    send_bot(rand128(), 6'h10, 1, 8'hA1);
    send_bot(rand128(), 6'h20, 1, 8'hA2);
    send_bot(rand128(), 6'h30, 0, 8'hA3);
    reset_dut(1);
    check("req41_sent", batchesSent, 32'd0);
    check("req41_ready", botReady, 1'b0);
    check("req41_write", writeData, 1'b0);
    cyc();
    send_bot(rand128(), 6'h05, 0, 8'hC3);
    send_bot(rand128(), 6'h06, 1, 8'h99);
    resultsAvailable = 1; resultReady = 1;
    cyc();
    resultsAvailable = 0;
    check("req41_tag", resultTag, 8'hC3);
    check("req41_perr", protocolError, 1'b0);
    cyc();

    // random traffic
    reset_dut(1);
    for (int i = 0; i < 500; i++) begin
      botValidIn       = ($urandom_range(0, 9) < 6);
      botIn            = rand128();
      botPermutesIn    = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom());
      botLastIn        = ($urandom_range(0, 9) < 3);
      batchTagIn       = 8'($urandom());
      slowDownInput    = ($urandom_range(0, 9) < 2);
      resultsAvailable = (tagq.size() > 0) && ($urandom_range(0, 9) < 4);
      resultReady      = ($urandom_range(0, 9) < 6);
      cyc();
    end
    botValidIn = 0; resultsAvailable = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
